// File: rtl/spi_pkg.sv
// spi_pkg: shared state encoding, default frame width and bit counter sizing for spi_resp
package spi_pkg;
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  localparam int SPI_WIDTH = 16;
  function automatic int cnt_w(input int w);
    return $clog2(w + 2);
  endfunction
endpackage

// File: rtl/spi_sync_edge.sv
// spi_sync_edge: 3-flop synchronizer; ports clk, rst_n, d in; q (ff2), rise, fall out; RST_VAL sets flop reset value
module spi_sync_edge #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);
  logic ff1, ff2, ff3;
  always_ff @(posedge clk)
    if (!rst_n) {ff1, ff2, ff3} <= {3{RST_VAL}};
    else {ff1, ff2, ff3} <= {d, ff1, ff2};
  assign q = ff2;
  assign rise = ff2 & ~ff3;
  assign fall = ~ff2 & ff3;
endmodule

// File: rtl/spi_resp.sv
// spi_resp: SPI mode-0 responder; ports clk, rst_n, SS_n/SCLK/MOSI in, MISO out, tx_data/tx_ld preload, rx_data/rdy/busy status, err when SPI_RESP_FRAME_CHK_EN is defined
module spi_resp
  import spi_pkg::*;
#(
  parameter int WIDTH = SPI_WIDTH,
  parameter logic [WIDTH-1:0] RESET_TX = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             SS_n,
  input  logic             SCLK,
  input  logic             MOSI,
  output logic             MISO,
  input  logic [WIDTH-1:0] tx_data,
  input  logic             tx_ld,
  output logic [WIDTH-1:0] rx_data,
  output logic             rdy,
  output logic             busy
`ifdef SPI_RESP_FRAME_CHK_EN
  , output logic           err
`endif
);
  localparam int CW = cnt_w(WIDTH);
  state_t state, nxt;
  logic [WIDTH-1:0] shft, tx_buf;
  logic [CW-1:0] bit_cnt;
  logic ss_rise, ss_fall, sclk_rise, mosi_s, done_ok;
  logic ss_unused, sclk_unused_q, sclk_unused_f, mosi_unused_r, mosi_unused_f;
  spi_sync_edge #(.RST_VAL(1'b1)) u_ss (.clk(clk), .rst_n(rst_n), .d(SS_n), .q(ss_unused), .rise(ss_rise), .fall(ss_fall));
  spi_sync_edge #(.RST_VAL(1'b1)) u_sclk (.clk(clk), .rst_n(rst_n), .d(SCLK), .q(sclk_unused_q), .rise(sclk_rise), .fall(sclk_unused_f));
  spi_sync_edge #(.RST_VAL(1'b0)) u_mosi (.clk(clk), .rst_n(rst_n), .d(MOSI), .q(mosi_s), .rise(mosi_unused_r), .fall(mosi_unused_f));
  always_ff @(posedge clk)
    if (!rst_n) state <= IDLE;
    else state <= nxt;
  always_comb
    nxt = state == IDLE  ? (ss_fall ? SHIFT : IDLE) :
          state == SHIFT ? (ss_rise ? DONE : SHIFT) : IDLE;
  always_comb begin
    MISO = (state != IDLE) & shft[WIDTH-1];
    done_ok = (state == DONE) && (bit_cnt == CW'(WIDTH));
  end
  // rdy is registered so it rises in the same cycle rx_data shows the new word
  always_ff @(posedge clk)
    if (!rst_n) begin
      shft <= '0;
      tx_buf <= RESET_TX;
      bit_cnt <= '0;
      busy <= 1'b0;
      rx_data <= '0;
      rdy <= 1'b0;
    end else begin
      rdy <= done_ok;
      if (tx_ld) tx_buf <= tx_data;
      if (state == IDLE && ss_fall) begin
        shft <= tx_ld ? tx_data : tx_buf;
        bit_cnt <= '0;
        busy <= 1'b1;
      end
      if (state == SHIFT && sclk_rise) begin
        shft <= {shft[WIDTH-2:0], mosi_s};
        if (bit_cnt != CW'(WIDTH + 1)) bit_cnt <= bit_cnt + CW'(1);
      end
      if (state == DONE) busy <= 1'b0;
      if (done_ok) rx_data <= shft;
    end
`ifdef SPI_RESP_FRAME_CHK_EN
  // frames with no SCLK edges leave err alone; a clean frame clears it
  always_ff @(posedge clk)
    if (!rst_n) err <= 1'b0;
    else if (state == DONE && bit_cnt != '0) err <= !done_ok;
`endif
endmodule

// File: tb/tb_spi_resp.sv
// tb_spi_resp: randomized scoreboard bench for spi_resp
module tb_spi_resp;
  localparam int W = 16;
  localparam logic [W-1:0] RTX = 16'h6A6A;
  logic clk = 0, rst_n = 0, SS_n = 1, SCLK = 0, MOSI = 0, tx_ld = 0;
  logic [W-1:0] tx_data = '0;
  logic MISO, rdy, busy;
  logic [W-1:0] rx_data;
`ifdef SPI_RESP_FRAME_CHK_EN
  logic err;
`endif
  int n_cmp = 0, n_bad = 0;
  logic [W-1:0] rxq[$];
  logic [W-1:0] model_buf = RTX, rx_exp = '0;
  bit err_exp = 0;
  spi_resp #(.WIDTH(W), .RESET_TX(RTX)) dut (
    .clk(clk), .rst_n(rst_n), .SS_n(SS_n), .SCLK(SCLK), .MOSI(MOSI), .MISO(MISO),
    .tx_data(tx_data), .tx_ld(tx_ld), .rx_data(rx_data), .rdy(rdy), .busy(busy)
`ifdef SPI_RESP_FRAME_CHK_EN
    , .err(err)
`endif
  );
  always #5 clk = ~clk;
  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask
  task automatic chk_err(input string nm);
`ifdef SPI_RESP_FRAME_CHK_EN
    check(nm, {31'd0, err}, {31'd0, err_exp});
`endif
  endtask
  always @(negedge clk)
    if (rst_n && rdy === 1'b1) begin
      if (rxq.size() == 0) check("unexpected rdy", {31'd0, rdy}, 32'd0);
      else check("rx_data at rdy", {16'd0, rx_data}, {16'd0, rxq.pop_front()});
    end
  task automatic load(input logic [W-1:0] v);
    tx_data = v;
    tx_ld = 1;
    @(negedge clk);
    tx_ld = 0;
    model_buf = v;
  endtask
  task automatic start_frame(input bit byp, input logic [W-1:0] v);
    SCLK = 0;
    SS_n = 0;
    repeat (2) @(negedge clk);
    if (byp) load(v);
  endtask
  task automatic xfer(input bit mo, output bit mi);
    MOSI = mo;
    repeat (8) @(negedge clk);
    SCLK = 1;
    mi = MISO;
    repeat (8) @(negedge clk);
    SCLK = 0;
  endtask
  task automatic end_frame(input int gap);
    repeat (8) @(negedge clk);
    SS_n = 1;
    repeat (gap) @(negedge clk);
  endtask
  task automatic frame(input int n, input logic [31:0] mo_w, input bit byp, input logic [W-1:0] byp_v,
                       input int ld_at, input logic [W-1:0] ld_v, input int gap);
    logic [W-1:0] word;
    logic [31:0] got, exp;
    bit mi;
    word = byp ? byp_v : model_buf;
    got = '0;
    exp = '0;
    // outgoing stream is the response word followed by the bits the master sent
    for (int i = 0; i < n; i++) exp[n-1-i] = i < W ? word[W-1-i] : mo_w[n-1-(i-W)];
    if (n == W) begin
      rxq.push_back(mo_w[W-1:0]);
      rx_exp = mo_w[W-1:0];
    end
    start_frame(byp, byp_v);
    for (int i = 0; i < n; i++) begin
      xfer(mo_w[n-1-i], mi);
      got[n-1-i] = mi;
      if (i == 0) begin
        check("busy in frame", {31'd0, busy}, 32'd1);
        chk_err("err carried into frame");
      end
      if (i == ld_at) load(ld_v);
    end
    end_frame(gap);
    check($sformatf("MISO word (%0d bits)", n), got, exp);
    if (n == W) err_exp = 0;
    else if (n != 0) err_exp = 1;
  endtask
  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end
  initial begin
    bit mi;
    int n, r;
    repeat (3) @(negedge clk);
    check("reset MISO", {31'd0, MISO}, 32'd0);
    check("reset busy", {31'd0, busy}, 32'd0);
    check("reset rdy", {31'd0, rdy}, 32'd0);
    check("reset rx_data", {16'd0, rx_data}, 32'd0);
    chk_err("reset err");
    rst_n = 1;
    repeat (3) @(negedge clk);
    load(16'hA5C3);
    frame(16, 32'h1234, 0, '0, -1, '0, 4);
    frame(16, $urandom, 1, 16'h0F0F, -1, '0, 4);
    load(16'h1111);
    frame(16, $urandom, 0, '0, 4, 16'hBEEF, 4);
    frame(16, $urandom, 0, '0, -1, '0, 4);
    frame(16, 32'h1234, 0, '0, -1, '0, 4);
    frame(12, 32'h0ABC, 0, '0, -1, '0, 4);
    frame(17, 32'h1F0F0, 0, '0, -1, '0, 6);
    check("rx_data kept after bad frames", {16'd0, rx_data}, 32'h1234);
    frame(16, 32'h00FF, 0, '0, -1, '0, 6);
    start_frame(0, '0);
    for (int i = 0; i < 8; i++) xfer(i[0], mi);
    rst_n = 0;
    SS_n = 1;
    @(negedge clk);
    rst_n = 1;
    model_buf = RTX;
    err_exp = 0;
    check("MISO after mid-frame reset", {31'd0, MISO}, 32'd0);
    check("busy after mid-frame reset", {31'd0, busy}, 32'd0);
    check("rx_data after mid-frame reset", {16'd0, rx_data}, 32'd0);
    repeat (4) @(negedge clk);
    frame(16, 32'h5555, 0, '0, -1, '0, 3);
    for (int k = 1; k <= 4; k++) frame(16, k, 0, '0, -1, '0, 3);
    repeat (4) @(negedge clk);
    check("rdy pending after back-to-back", rxq.size(), 0);
    for (int k = 0; k < 30; k++) begin
      r = $urandom_range(0, 4);
      n = r < 3 ? W : (r == 3 ? $urandom_range(8, W - 1) : $urandom_range(W + 1, 20));
      frame(n, $urandom, $urandom_range(0, 3) == 0, W'($urandom),
            $urandom_range(0, 2) == 0 ? $urandom_range(0, n - 2) : -1, W'($urandom), $urandom_range(3, 6));
    end
    repeat (10) @(negedge clk);
    check("final rx_data", {16'd0, rx_data}, {16'd0, rx_exp});
    check("final busy", {31'd0, busy}, 32'd0);
    check("rdy pending at end", rxq.size(), 0);
    chk_err("final err");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/spi_resp.md
Name: spi_resp

Overview:
- Synthesizable SPI responder (slave), mode 0, fixed-length frames. It is the opposite end of the SPI master used by the A2D and inertial interfaces.
- Serves as the A2D/inertial sensor model in fullchip benches and as a loopback target on the DE0-Nano.
- Shifts a preloaded response word out on MISO while capturing the master's command word from MOSI.
- Presents each completed command word with a one-cycle ready pulse.

Parameters:
- WIDTH, 16, frame length in bits; legal range 8..32.
- RESET_TX, 16'h0000, response word held in tx_buf after reset.

Ports:
- clk  input  1  system clock
- rst_n  input  1  synchronous active-low reset
- SS_n  input  1  slave select from master, asynchronous to clk
- SCLK  input  1  serial clock from master, asynchronous to clk
- MOSI  input  1  serial data from master, asynchronous to clk
- MISO  output  1  serial data to master
- tx_data  input  WIDTH  response word for the next frame
- tx_ld  input  1  load strobe; one clk pulse writes tx_data into tx_buf
- rx_data  output  WIDTH  last complete command word received
- rdy  output  1  one-clk pulse when rx_data is updated
- busy  output  1  high while a frame is in progress
- err  output  1  frame-length error flag (present only when the optional feature is enabled)

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-low (rst_n sampled on posedge clk).
- Reset values: MISO=0, rx_data=0, rdy=0, busy=0, err=0, tx_buf=RESET_TX, state=IDLE, bit_cnt=0.
- Synchronizers:
  - SS_n, SCLK and MOSI each pass through a 2-flop synchronizer, followed by a third flop for edge detection.
  - SS_n and SCLK synchronizer flops reset to 1; MOSI synchronizer flops reset to 0.
  - SCLK rise = ff2 & ~ff3. SS_n fall and SS_n rise are detected the same way.
- Master timing requirements: SCLK high and low phases each >= 4 clk; SS_n fall to first SCLK rise >= 4 clk; last SCLK fall to SS_n rise >= 4 clk.
- State IDLE:
  - On SS_n fall: shft <= tx_buf, bit_cnt <= 0, busy <= 1, go to SHIFT.
  - If tx_ld is high in that same cycle, shft <= tx_data (bypass) and tx_buf <= tx_data.
- State SHIFT:
  - On each SCLK rise: shft <= {shft[WIDTH-2:0], MOSI_ff2}; bit_cnt saturates at WIDTH+1.
  - SCLK falls are ignored.
  - On SS_n rise, go to DONE.
- State DONE (one clk):
  - busy <= 0.
  - If bit_cnt==WIDTH: rx_data <= shft and rdy=1 for this cycle.
  - Otherwise rx_data is unchanged and rdy=0.
  - Return to IDLE.
- MISO = shft[WIDTH-1] while state != IDLE, else 0. The first response bit is valid from SS_n fall; each subsequent bit is valid about 3 clk after SCLK rise, which lands before the master's next rise sample.
- tx_ld while in SHIFT/DONE: updates tx_buf only and takes effect on the next frame. The current frame is unaffected.
- Frame too long (bit_cnt > WIDTH): shft holds the last WIDTH bits, but rx_data is not updated.
- Frame too short: rx_data is not updated.
- SS_n rise with zero SCLK edges: no rdy.
- SCLK edges while SS_n is high are ignored.
- rst_n low mid-frame: everything returns to reset values on the next clk edge. A partial frame is discarded with no rdy.
- Back-to-back frames: SS_n high for >= 3 clk between frames is required.

Optional Feature:
- Macro: SPI_RESP_FRAME_CHK_EN.
- When defined:
  - In DONE, err <= 1 if bit_cnt != WIDTH and bit_cnt != 0.
  - err is sticky until the next frame that completes with exactly WIDTH bits, which clears it in that frame's DONE cycle.
  - Reset clears err.
- When undefined: the err port is absent, and bad frames are silently dropped as described above.

Decomposition:
- Package spi_pkg holds:
  - the state enum (IDLE, SHIFT, DONE);
  - the default SPI_WIDTH=16 constant;
  - the bit_cnt width function clog2(WIDTH+2).
- One sub-module, spi_sync_edge: a 3-flop synchronizer with rise/fall outputs and a reset-value parameter. It is instantiated three times (SS_n, SCLK, MOSI); the MOSI instance uses the ff2 tap only.

Test Plan:
- Basic frame: tx_ld with tx_data=16'hA5C3, then a 16-bit frame with MOSI=16'h1234 (SCLK half-period 8 clk) -> master sees 16'hA5C3 on MISO; rx_data=16'h1234 with one rdy pulse about 4 clk after SS_n rise; busy high throughout.
- Bypass: tx_ld with 16'h0F0F in the same clk as SS_n fall is detected -> MISO frame reads 16'h0F0F.
- Mid-frame load: tx_ld 16'hBEEF after 5 SCLK rises of a frame preloaded with 16'h1111 -> this frame returns 16'h1111, the next frame returns 16'hBEEF.
- Short and long frames:
  - 12-bit frame then 17-bit frame -> no rdy, rx_data keeps its prior value 16'h1234.
  - With SPI_RESP_FRAME_CHK_EN, err=1 after the 12-bit frame and stays 1 after the 17-bit frame.
  - A following good frame with MOSI=16'h00FF sets rx_data=16'h00FF and clears err.
- Reset mid-frame: rst_n low for 1 clk after 8 bits -> MISO=0, busy=0, no rdy, tx_buf=RESET_TX. The next complete frame with MOSI=16'h5555 sets rx_data=16'h5555.
- Back-to-back frames: 4 frames with 3 clk SS_n-high gaps and MOSI=16'h0001..16'h0004 -> exactly 4 rdy pulses with matching rx_data.
